// File: rtl/vx_rop_dcr_bank_pkg.sv
// Shared ROP DCR types: register map, field encodings, per-context state struct and bank FSM states.
// Pure declarations; no timing or flow control.
package vx_rop_dcr_bank_pkg;

  localparam int DCR_ADDR_BITS = 8;

  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_CBUF_ADDR         = 8'h10;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_CBUF_PITCH        = 8'h11;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_CBUF_WRITEMASK    = 8'h12;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_ZBUF_ADDR         = 8'h13;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_ZBUF_PITCH        = 8'h14;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_DEPTH_FUNC        = 8'h15;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_DEPTH_WRITEMASK   = 8'h16;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_FUNC      = 8'h17;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_ZPASS     = 8'h18;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_ZFAIL     = 8'h19;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_FAIL      = 8'h1A;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_REF       = 8'h1B;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_MASK      = 8'h1C;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_STENCIL_WRITEMASK = 8'h1D;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_BLEND_MODE        = 8'h1E;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_BLEND_FUNC        = 8'h1F;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_BLEND_CONST       = 8'h20;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_ROP_LOGIC_OP          = 8'h21;

  localparam logic [2:0] ROP_DEPTH_FUNC_LESS   = 3'd1;
  localparam logic [2:0] ROP_DEPTH_FUNC_ALWAYS = 3'd7;
  localparam logic [2:0] ROP_STENCIL_OP_KEEP   = 3'd0;
  localparam logic [2:0] ROP_BLEND_MODE_ADD    = 3'd0;
  localparam logic [3:0] ROP_BLEND_FUNC_ZERO   = 4'd0;
  localparam logic [3:0] ROP_BLEND_FUNC_ONE    = 4'd1;
  localparam logic [3:0] ROP_LOGIC_OP_COPY     = 4'd3;

  // Stencil arrays: index 0 = front face, 1 = back face.
  typedef struct packed {
    logic [31:0]      cbuf_addr;
    logic [31:0]      cbuf_pitch;
    logic [3:0]       cbuf_writemask;
    logic [31:0]      zbuf_addr;
    logic [31:0]      zbuf_pitch;
    logic [2:0]       depth_func;
    logic             depth_writemask;
    logic [1:0][2:0]  stencil_func;
    logic [1:0][2:0]  stencil_zpass;
    logic [1:0][2:0]  stencil_zfail;
    logic [1:0][2:0]  stencil_fail;
    logic [1:0][7:0]  stencil_ref;
    logic [1:0][7:0]  stencil_mask;
    logic [1:0][7:0]  stencil_writemask;
    logic [2:0]       blend_mode_rgb;
    logic [2:0]       blend_mode_a;
    logic [3:0]       blend_src_rgb;
    logic [3:0]       blend_src_a;
    logic [3:0]       blend_dst_rgb;
    logic [3:0]       blend_dst_a;
    logic [31:0]      blend_const;
    logic [3:0]       logic_op;
    logic             depth_enable;
    logic [1:0]       stencil_enable;
    logic             blend_enable;
  } rop_dcrs_t;

  localparam rop_dcrs_t ROP_DCR_DEFAULTS = '{
    cbuf_addr:         32'h0,
    cbuf_pitch:        32'h0,
    cbuf_writemask:    4'hF,
    zbuf_addr:         32'h0,
    zbuf_pitch:        32'h0,
    depth_func:        ROP_DEPTH_FUNC_ALWAYS,
    depth_writemask:   1'b0,
    stencil_func:      {2{ROP_DEPTH_FUNC_ALWAYS}},
    stencil_zpass:     {2{ROP_STENCIL_OP_KEEP}},
    stencil_zfail:     {2{ROP_STENCIL_OP_KEEP}},
    stencil_fail:      {2{ROP_STENCIL_OP_KEEP}},
    stencil_ref:       16'h0000,
    stencil_mask:      16'hFFFF,
    stencil_writemask: 16'hFFFF,
    blend_mode_rgb:    ROP_BLEND_MODE_ADD,
    blend_mode_a:      ROP_BLEND_MODE_ADD,
    blend_src_rgb:     ROP_BLEND_FUNC_ONE,
    blend_src_a:       ROP_BLEND_FUNC_ONE,
    blend_dst_rgb:     ROP_BLEND_FUNC_ZERO,
    blend_dst_a:       ROP_BLEND_FUNC_ZERO,
    blend_const:       32'h0,
    logic_op:          ROP_LOGIC_OP_COPY,
    depth_enable:      1'b0,
    stencil_enable:    2'b00,
    blend_enable:      1'b0
  };

  typedef enum logic [1:0] {
    ROP_BANK_RUN,
    ROP_BANK_DRAIN,
    ROP_BANK_SWITCH
  } rop_bank_state_e;

  function automatic logic rop_stencil_en(input logic [2:0] func,
                                          input logic [2:0] zpass,
                                          input logic [2:0] zfail);
    return !(func == ROP_DEPTH_FUNC_ALWAYS && zpass == ROP_STENCIL_OP_KEEP &&
             zfail == ROP_STENCIL_OP_KEEP);
  endfunction

endpackage

// File: rtl/vx_rop_dcr_derive.sv
// Fills depth/stencil/blend enables from raw DCR fields; all other fields pass through.
// Purely combinational, no flow control.
module vx_rop_dcr_derive
  import vx_rop_dcr_bank_pkg::*;
(
  input  rop_dcrs_t i_dcrs,
  output rop_dcrs_t o_dcrs
);

  always_comb begin
    o_dcrs = i_dcrs;
    o_dcrs.depth_enable = !(i_dcrs.depth_func == ROP_DEPTH_FUNC_ALWAYS && !i_dcrs.depth_writemask);
    for (int i = 0; i < 2; i++) begin
      o_dcrs.stencil_enable[i] = rop_stencil_en(i_dcrs.stencil_func[i],
                                                i_dcrs.stencil_zpass[i],
                                                i_dcrs.stencil_zfail[i]);
    end
    o_dcrs.blend_enable = !(i_dcrs.blend_mode_rgb == ROP_BLEND_MODE_ADD &&
                            i_dcrs.blend_mode_a   == ROP_BLEND_MODE_ADD &&
                            i_dcrs.blend_src_rgb  == ROP_BLEND_FUNC_ONE &&
                            i_dcrs.blend_src_a    == ROP_BLEND_FUNC_ONE &&
                            i_dcrs.blend_dst_rgb  == ROP_BLEND_FUNC_ZERO &&
                            i_dcrs.blend_dst_a    == ROP_BLEND_FUNC_ZERO);
  end

endmodule

// File: rtl/vx_rop_dcr_bank.sv
// Multi-context ROP DCR bank: shadow writes, commit into a context ring, switch after in-flight drain.
// Read-back 1 cycle; commit_ready drops when the ring is full, req_ready drops while draining.
module vx_rop_dcr_bank
  import vx_rop_dcr_bank_pkg::*;
#(
  parameter int    NUM_CTX      = 2,
  parameter int    MAX_INFLIGHT = 64,
  parameter string INSTANCE_ID  = ""
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         dcr_wr_valid,
  input  logic [DCR_ADDR_BITS-1:0]     dcr_wr_addr,
  input  logic [31:0]                  dcr_wr_data,
  input  logic [DCR_ADDR_BITS-1:0]     dcr_rd_addr,
  output logic [31:0]                  dcr_rd_data,
  input  logic                         commit_valid,
  output logic                         commit_ready,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         rsp_done,
  output rop_dcrs_t                    rop_dcrs,
  output logic [$clog2(NUM_CTX)-1:0]   active_ctx,
  output logic [$clog2(NUM_CTX):0]     pending_cnt
);

  localparam int CTX_W = $clog2(NUM_CTX);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CTX_W-1:0] CTX_ONE     = CTX_W'(1);
  localparam logic [CTX_W:0]   PEND_ONE    = (CTX_W + 1)'(1);
  localparam logic [CTX_W:0]   PEND_MAX    = (CTX_W + 1)'(NUM_CTX - 1);
  localparam logic [INF_W-1:0] INF_ONE     = INF_W'(1);
  localparam logic [INF_W-1:0] INF_MAX     = INF_W'(MAX_INFLIGHT);

  rop_dcrs_t       r_shadow;
  rop_dcrs_t       w_shadow_next;
  rop_dcrs_t       w_snapshot;
  rop_dcrs_t       r_slots [NUM_CTX];
  rop_dcrs_t       r_rop_dcrs;
  rop_bank_state_e r_state;
  logic [CTX_W-1:0] r_active;
  logic [CTX_W-1:0] r_wr_ptr;
  logic [CTX_W-1:0] w_next_active;
  logic [CTX_W:0]   r_pending;
  logic [INF_W-1:0] r_inflight;
  logic [31:0]      r_rd_data;
  logic [31:0]      w_rd_data;
  logic             w_commit_ready;
  logic             w_commit_fire;
  logic             w_req_ready;
  logic             w_req_fire;
  logic             w_switch;

  assign w_commit_ready = (r_pending < PEND_MAX);
  assign w_commit_fire  = commit_valid && w_commit_ready;
  assign w_req_ready    = (r_state == ROP_BANK_RUN);
  assign w_req_fire     = req_valid && w_req_ready;
  assign w_switch       = (r_state == ROP_BANK_SWITCH);
  assign w_next_active  = r_active + CTX_ONE;

  // The commit snapshot sees this cycle's write, so write+commit together is captured.
  always_comb begin
    w_shadow_next = r_shadow;
    if (dcr_wr_valid) begin
      case (dcr_wr_addr)
        DCR_ROP_CBUF_ADDR:         w_shadow_next.cbuf_addr       = dcr_wr_data;
        DCR_ROP_CBUF_PITCH:        w_shadow_next.cbuf_pitch      = dcr_wr_data;
        DCR_ROP_CBUF_WRITEMASK:    w_shadow_next.cbuf_writemask  = dcr_wr_data[3:0];
        DCR_ROP_ZBUF_ADDR:         w_shadow_next.zbuf_addr       = dcr_wr_data;
        DCR_ROP_ZBUF_PITCH:        w_shadow_next.zbuf_pitch      = dcr_wr_data;
        DCR_ROP_DEPTH_FUNC:        w_shadow_next.depth_func      = dcr_wr_data[2:0];
        DCR_ROP_DEPTH_WRITEMASK:   w_shadow_next.depth_writemask = dcr_wr_data[0];
        DCR_ROP_STENCIL_FUNC:      w_shadow_next.stencil_func    = {dcr_wr_data[18:16], dcr_wr_data[2:0]};
        DCR_ROP_STENCIL_ZPASS:     w_shadow_next.stencil_zpass   = {dcr_wr_data[18:16], dcr_wr_data[2:0]};
        DCR_ROP_STENCIL_ZFAIL:     w_shadow_next.stencil_zfail   = {dcr_wr_data[18:16], dcr_wr_data[2:0]};
        DCR_ROP_STENCIL_FAIL:      w_shadow_next.stencil_fail    = {dcr_wr_data[18:16], dcr_wr_data[2:0]};
        DCR_ROP_STENCIL_REF:       w_shadow_next.stencil_ref     = {dcr_wr_data[23:16], dcr_wr_data[7:0]};
        DCR_ROP_STENCIL_MASK:      w_shadow_next.stencil_mask    = {dcr_wr_data[23:16], dcr_wr_data[7:0]};
        DCR_ROP_STENCIL_WRITEMASK: w_shadow_next.stencil_writemask = {dcr_wr_data[23:16], dcr_wr_data[7:0]};
        DCR_ROP_BLEND_MODE: begin
          w_shadow_next.blend_mode_rgb = dcr_wr_data[2:0];
          w_shadow_next.blend_mode_a   = dcr_wr_data[18:16];
        end
        DCR_ROP_BLEND_FUNC: begin
          w_shadow_next.blend_src_rgb = dcr_wr_data[3:0];
          w_shadow_next.blend_src_a   = dcr_wr_data[11:8];
          w_shadow_next.blend_dst_rgb = dcr_wr_data[19:16];
          w_shadow_next.blend_dst_a   = dcr_wr_data[27:24];
        end
        DCR_ROP_BLEND_CONST:       w_shadow_next.blend_const     = dcr_wr_data;
        DCR_ROP_LOGIC_OP:          w_shadow_next.logic_op        = dcr_wr_data[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (dcr_rd_addr)
      DCR_ROP_CBUF_ADDR:         w_rd_data = r_shadow.cbuf_addr;
      DCR_ROP_CBUF_PITCH:        w_rd_data = r_shadow.cbuf_pitch;
      DCR_ROP_CBUF_WRITEMASK:    w_rd_data[3:0] = r_shadow.cbuf_writemask;
      DCR_ROP_ZBUF_ADDR:         w_rd_data = r_shadow.zbuf_addr;
      DCR_ROP_ZBUF_PITCH:        w_rd_data = r_shadow.zbuf_pitch;
      DCR_ROP_DEPTH_FUNC:        w_rd_data[2:0] = r_shadow.depth_func;
      DCR_ROP_DEPTH_WRITEMASK:   w_rd_data[0] = r_shadow.depth_writemask;
      DCR_ROP_STENCIL_FUNC:      {w_rd_data[18:16], w_rd_data[2:0]} = r_shadow.stencil_func;
      DCR_ROP_STENCIL_ZPASS:     {w_rd_data[18:16], w_rd_data[2:0]} = r_shadow.stencil_zpass;
      DCR_ROP_STENCIL_ZFAIL:     {w_rd_data[18:16], w_rd_data[2:0]} = r_shadow.stencil_zfail;
      DCR_ROP_STENCIL_FAIL:      {w_rd_data[18:16], w_rd_data[2:0]} = r_shadow.stencil_fail;
      DCR_ROP_STENCIL_REF:       {w_rd_data[23:16], w_rd_data[7:0]} = r_shadow.stencil_ref;
      DCR_ROP_STENCIL_MASK:      {w_rd_data[23:16], w_rd_data[7:0]} = r_shadow.stencil_mask;
      DCR_ROP_STENCIL_WRITEMASK: {w_rd_data[23:16], w_rd_data[7:0]} = r_shadow.stencil_writemask;
      DCR_ROP_BLEND_MODE: begin
        w_rd_data[2:0]   = r_shadow.blend_mode_rgb;
        w_rd_data[18:16] = r_shadow.blend_mode_a;
      end
      DCR_ROP_BLEND_FUNC: begin
        w_rd_data[3:0]   = r_shadow.blend_src_rgb;
        w_rd_data[11:8]  = r_shadow.blend_src_a;
        w_rd_data[19:16] = r_shadow.blend_dst_rgb;
        w_rd_data[27:24] = r_shadow.blend_dst_a;
      end
      DCR_ROP_BLEND_CONST:       w_rd_data = r_shadow.blend_const;
      DCR_ROP_LOGIC_OP:          w_rd_data[3:0] = r_shadow.logic_op;
      default: ;
    endcase
  end

  vx_rop_dcr_derive u_derive (
    .i_dcrs (w_shadow_next),
    .o_dcrs (w_snapshot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= ROP_DCR_DEFAULTS;
      r_rd_data <= '0;
      for (int i = 0; i < NUM_CTX; i++) begin
        r_slots[i] <= ROP_DCR_DEFAULTS;
      end
    end else begin
      r_shadow  <= w_shadow_next;
      r_rd_data <= w_rd_data;
      if (w_commit_fire) begin
        r_slots[r_wr_ptr] <= w_snapshot;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= '0;
    end else if (w_req_fire && !rsp_done && r_inflight != INF_MAX) begin
      r_inflight <= r_inflight + INF_ONE;
    end else if (!w_req_fire && rsp_done && r_inflight != '0) begin
      r_inflight <= r_inflight - INF_ONE;
    end
  end

  // The write pointer never reaches the active slot: at most NUM_CTX-1 contexts are pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ROP_BANK_RUN;
      r_active   <= '0;
      r_wr_ptr   <= CTX_ONE;
      r_pending  <= '0;
      r_rop_dcrs <= ROP_DCR_DEFAULTS;
    end else begin
      if (w_commit_fire) begin
        r_wr_ptr <= r_wr_ptr + CTX_ONE;
      end
      case ({w_commit_fire, w_switch})
        2'b10:   r_pending <= r_pending + PEND_ONE;
        2'b01:   r_pending <= r_pending - PEND_ONE;
        default: ;
      endcase
      case (r_state)
        ROP_BANK_RUN: begin
          if (r_pending != '0) r_state <= ROP_BANK_DRAIN;
        end
        ROP_BANK_DRAIN: begin
          if (r_inflight == '0) r_state <= ROP_BANK_SWITCH;
        end
        ROP_BANK_SWITCH: begin
          r_active   <= w_next_active;
          r_rop_dcrs <= r_slots[w_next_active];
          r_state    <= ROP_BANK_RUN;
        end
        default: r_state <= ROP_BANK_RUN;
      endcase
    end
  end

  assign dcr_rd_data  = r_rd_data;
  assign commit_ready = w_commit_ready;
  assign req_ready    = w_req_ready;
  assign rop_dcrs     = r_rop_dcrs;
  assign active_ctx   = r_active;
  assign pending_cnt  = r_pending;

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_done && r_inflight == '0))
    else $error("%s: rsp_done with no request in flight", INSTANCE_ID);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_req_fire && !rsp_done && r_inflight == INF_MAX))
    else $error("%s: in-flight count exceeds MAX_INFLIGHT", INSTANCE_ID);

endmodule

// File: tb/tb_vx_rop_dcr_bank.sv
// Directed bench: a 2-context bank for reset/order/drain/full/same-cycle cases, a 4-context bank for wrap.
module tb_vx_rop_dcr_bank;
  import vx_rop_dcr_bank_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dcr_wr_valid;
  logic [7:0]  dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic [7:0]  dcr_rd_addr;
  logic [31:0] dcr_rd_data;
  logic        commit_valid, commit_ready;
  logic        req_valid, req_ready, rsp_done;
  rop_dcrs_t   rop_dcrs;
  logic [0:0]  active_ctx;
  logic [1:0]  pending_cnt;

  logic        commit_valid_b, commit_ready_b, req_ready_b;
  logic [31:0] dcr_rd_data_b;
  rop_dcrs_t   rop_dcrs_b;
  logic [1:0]  active_ctx_b;
  logic [2:0]  pending_cnt_b;

  int errors = 0;
  int checks = 0;
  rop_dcrs_t saved;

  always #5 clk = ~clk;

  vx_rop_dcr_bank #(.NUM_CTX(2), .MAX_INFLIGHT(64), .INSTANCE_ID("bank2")) u_dut (
    .clk(clk), .reset_n(reset_n),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .dcr_rd_addr(dcr_rd_addr), .dcr_rd_data(dcr_rd_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .req_valid(req_valid), .req_ready(req_ready), .rsp_done(rsp_done),
    .rop_dcrs(rop_dcrs), .active_ctx(active_ctx), .pending_cnt(pending_cnt)
  );

  vx_rop_dcr_bank #(.NUM_CTX(4), .MAX_INFLIGHT(64), .INSTANCE_ID("bank4")) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .dcr_wr_valid(1'b0), .dcr_wr_addr(8'h00), .dcr_wr_data(32'h0),
    .dcr_rd_addr(DCR_ROP_CBUF_WRITEMASK), .dcr_rd_data(dcr_rd_data_b),
    .commit_valid(commit_valid_b), .commit_ready(commit_ready_b),
    .req_valid(1'b0), .req_ready(req_ready_b), .rsp_done(1'b0),
    .rop_dcrs(rop_dcrs_b), .active_ctx(active_ctx_b), .pending_cnt(pending_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dcrs(input string tag, input rop_dcrs_t obs, input rop_dcrs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = addr;
    dcr_wr_data  = data;
    tick();
    dcr_wr_valid = 1'b0;
  endtask

  task automatic commit1();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic wait_active(input string tag, input logic [0:0] exp);
    int n = 0;
    while (active_ctx !== exp && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(active_ctx), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_seq [9];
    int sw;
    int n;
    logic [1:0] prev;

    reset_n = 1'b0;
    dcr_wr_valid = 1'b0; dcr_wr_addr = '0; dcr_wr_data = '0;
    dcr_rd_addr = DCR_ROP_CBUF_WRITEMASK;
    commit_valid = 1'b0; req_valid = 1'b0; rsp_done = 1'b0; commit_valid_b = 1'b0;
    #23 reset_n = 1'b1;
    tick();

    chk_dcrs("rst_dcrs", rop_dcrs, ROP_DCR_DEFAULTS);
    chk("rst_active", 32'(active_ctx), 32'd0);
    chk("rst_pending", 32'(pending_cnt), 32'd0);
    chk("rst_commit_rdy", 32'(commit_ready), 32'd1);
    chk("rst_req_rdy", 32'(req_ready), 32'd1);
    chk("rd_wmask", dcr_rd_data, 32'hF);

    // Writemask first, then func.
    wr(DCR_ROP_DEPTH_WRITEMASK, 32'd1);
    wr(DCR_ROP_DEPTH_FUNC, 32'(ROP_DEPTH_FUNC_LESS));
    commit1();
    wait_active("sw_a", 1'b1);
    chk("depth_en_a", 32'(rop_dcrs.depth_enable), 32'd1);
    chk("pend_after_sw", 32'(pending_cnt), 32'd0);
    dcr_rd_addr = DCR_ROP_DEPTH_FUNC;
    tick();
    chk("rd_depth_func", dcr_rd_data, 32'd1);

    wr(DCR_ROP_DEPTH_FUNC, 32'(ROP_DEPTH_FUNC_ALWAYS));
    wr(DCR_ROP_DEPTH_WRITEMASK, 32'd0);
    commit1();
    wait_active("sw_b", 1'b0);
    chk("depth_en_off", 32'(rop_dcrs.depth_enable), 32'd0);
    chk("depth_func_always", 32'(rop_dcrs.depth_func), 32'd7);

    // Func first, then writemask: same enable.
    wr(DCR_ROP_DEPTH_FUNC, 32'(ROP_DEPTH_FUNC_LESS));
    wr(DCR_ROP_DEPTH_WRITEMASK, 32'd1);
    commit1();
    wait_active("sw_c", 1'b1);
    chk("depth_en_rev", 32'(rop_dcrs.depth_enable), 32'd1);

    wr(DCR_ROP_STENCIL_ZPASS, 32'h0002_0000);
    wr(DCR_ROP_BLEND_MODE, 32'h0001_0000);
    commit1();
    wait_active("sw_d", 1'b0);
    chk("stencil_en", 32'(rop_dcrs.stencil_enable), 32'd2);
    chk("blend_en", 32'(rop_dcrs.blend_enable), 32'd1);
    chk("zpass_back", 32'(rop_dcrs.stencil_zpass[1]), 32'd2);
    chk("blend_mode_a", 32'(rop_dcrs.blend_mode_a), 32'd1);
    dcr_rd_addr = DCR_ROP_STENCIL_ZPASS;
    tick();
    chk("rd_zpass", dcr_rd_data, 32'h0002_0000);

    // Write and commit in the same cycle.
    dcr_wr_valid = 1'b1; dcr_wr_addr = DCR_ROP_BLEND_CONST; dcr_wr_data = 32'hDEAD_BEEF;
    commit_valid = 1'b1;
    tick();
    dcr_wr_valid = 1'b0; commit_valid = 1'b0;
    wait_active("sw_e", 1'b1);
    chk("same_cycle_const", rop_dcrs.blend_const, 32'hDEAD_BEEF);

    // Drain: three requests outstanding hold the switch.
    saved = rop_dcrs;
    wr(DCR_ROP_BLEND_CONST, 32'h1234_5678);
    req_valid = 1'b1;
    repeat (3) tick();
    req_valid = 1'b0;
    commit1();
    chk("drain_rdy_lag", 32'(req_ready), 32'd1);
    tick();
    chk("drain_rdy", 32'(req_ready), 32'd0);
    repeat (4) tick();
    chk("drain_hold_ctx", 32'(active_ctx), 32'd1);
    chk_dcrs("drain_hold_dcrs", rop_dcrs, saved);
    chk("drain_pending", 32'(pending_cnt), 32'd1);
    rsp_done = 1'b1;
    repeat (3) tick();
    rsp_done = 1'b0;
    chk("drain_done0", 32'(active_ctx), 32'd1);
    tick();
    chk("drain_done1", 32'(active_ctx), 32'd1);
    tick();
    chk("drain_done2", 32'(active_ctx), 32'd0);
    chk("drain_const", rop_dcrs.blend_const, 32'h1234_5678);
    chk("drain_rdy_back", 32'(req_ready), 32'd1);

    // Full ring: second commit waits for the switch.
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wr(DCR_ROP_BLEND_CONST, 32'hAAAA_0001);
    commit_valid = 1'b1;
    tick();
    dcr_wr_valid = 1'b1; dcr_wr_addr = DCR_ROP_BLEND_CONST; dcr_wr_data = 32'hBBBB_0002;
    tick();
    dcr_wr_valid = 1'b0;
    repeat (3) tick();
    chk("full_stall", 32'(commit_ready), 32'd0);
    chk("full_pending", 32'(pending_cnt), 32'd1);
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    n = 0;
    while (commit_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("full_ready_back", 32'(commit_ready), 32'd1);
    chk("full_active", 32'(active_ctx), 32'd1);
    chk("full_first_const", rop_dcrs.blend_const, 32'hAAAA_0001);
    tick();
    commit_valid = 1'b0;
    chk("full_second_pending", 32'(pending_cnt), 32'd1);
    wait_active("full_sw2", 1'b0);
    chk("full_second_const", rop_dcrs.blend_const, 32'hBBBB_0002);

    // Asynchronous reset in the middle of a drain.
    req_valid = 1'b1;
    repeat (2) tick();
    req_valid = 1'b0;
    commit1();
    tick();
    chk("mid_drain_rdy", 32'(req_ready), 32'd0);
    #3 reset_n = 1'b0;
    #1;
    chk_dcrs("arst_dcrs", rop_dcrs, ROP_DCR_DEFAULTS);
    chk("arst_active", 32'(active_ctx), 32'd0);
    chk("arst_pending", 32'(pending_cnt), 32'd0);
    chk("arst_commit_rdy", 32'(commit_ready), 32'd1);
    chk("arst_req_rdy", 32'(req_ready), 32'd1);
    chk("arst_rd_data", dcr_rd_data, 32'd0);
    reset_n = 1'b1;
    tick();
    commit1();
    wait_active("post_rst_sw", 1'b1);
    chk_dcrs("post_rst_dcrs", rop_dcrs, ROP_DCR_DEFAULTS);

    // Four-context ring with commit held high.
    exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    sw = 0;
    prev = active_ctx_b;
    commit_valid_b = 1'b1;
    for (int c = 0; c < 200 && sw < 9; c++) begin
      tick();
      chk("b_pend_max", 32'(pending_cnt_b <= 3'd3), 32'd1);
      if (active_ctx_b !== prev) begin
        chk($sformatf("b_seq%0d", sw), 32'(active_ctx_b), 32'(exp_seq[sw]));
        prev = active_ctx_b;
        sw++;
      end
    end
    commit_valid_b = 1'b0;
    chk("b_switches", 32'(sw), 32'd9);
    n = 0;
    while (pending_cnt_b !== 3'd0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("b_drained", 32'(pending_cnt_b), 32'd0);
    chk("b_req_rdy", 32'(req_ready_b), 32'd1);
    chk("b_rd_wmask", dcr_rd_data_b, 32'hF);
    chk_dcrs("b_dcrs", rop_dcrs_b, ROP_DCR_DEFAULTS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
